// File: rtl/divider_26_12.sv
// Sequential signed divider, radix-2 restoring on magnitudes.
// One quotient bit per enabled clock; saturating 14-bit quotient.
module divider_26_12 #(
  parameter int WIDTH_N = 26,
  parameter int WIDTH_D = 12,
  parameter int WIDTH_Q = 14
) (
  input  logic               clock,
  input  logic               aclr_n,
  input  logic               clken,
  input  logic               start,
  input  logic [WIDTH_N-1:0] dataa,
  input  logic [WIDTH_D-1:0] datab,
  output logic               ready,
  output logic               done,
  output logic [WIDTH_Q-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder,
  output logic               ovf,
  output logic               dz
);

  localparam int CW = $clog2(WIDTH_N);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH_N - 1);
  localparam logic [WIDTH_N-1:0] MAG_POS = WIDTH_N'((1 << (WIDTH_Q - 1)) - 1);
  localparam logic [WIDTH_N-1:0] MAG_NEG = WIDTH_N'(1 << (WIDTH_Q - 1));
  localparam logic [WIDTH_Q-1:0] Q_POS = {1'b0, {(WIDTH_Q-1){1'b1}}};
  localparam logic [WIDTH_Q-1:0] Q_NEG = {1'b1, {(WIDTH_Q-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH_N-1:0] nq;
  logic [WIDTH_D-1:0] dmag;
  logic [WIDTH_D-1:0] prem;
  logic [CW-1:0]      cnt;
  logic               sa, sb, dzr;

  logic [WIDTH_N-1:0] amag;
  logic [WIDTH_D-1:0] bmag;
  logic [WIDTH_D:0]   shifted;
  logic               qbit;
  logic               neg, ovf_c;
  logic [WIDTH_Q-1:0] q_lo, q_sgn, q_fix;
  logic [WIDTH_D-1:0] r_fix;

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state <= IDLE;
    end else if (clken) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
  end

  always_comb begin
    amag = dataa[WIDTH_N-1] ? -dataa : dataa;
    bmag = datab[WIDTH_D-1] ? -datab : datab;
    shifted = {prem, nq[WIDTH_N-1]};
    qbit = (shifted >= {1'b0, dmag});
  end

  // Lower quotient bits of the negation depend only on lower magnitude bits.
  always_comb begin
    neg = sa ^ sb;
    ovf_c = neg ? (nq > MAG_NEG) : (nq > MAG_POS);
    q_lo = nq[WIDTH_Q-1:0];
    q_sgn = neg ? -q_lo : q_lo;
    q_fix = q_sgn;
    r_fix = sa ? -prem : prem;
    if (dzr) begin
      q_fix = sa ? Q_NEG : Q_POS;
      r_fix = '0;
    end else if (ovf_c) begin
      q_fix = neg ? Q_NEG : Q_POS;
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      nq        <= '0;
      dmag      <= '0;
      prem      <= '0;
      cnt       <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      dzr       <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
    end else if (clken) begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            nq   <= amag;
            dmag <= bmag;
            prem <= '0;
            sa   <= dataa[WIDTH_N-1];
            sb   <= datab[WIDTH_D-1];
            dzr  <= (datab == '0);
            cnt  <= CNT_LOAD;
          end
        end
        CALC: begin
          prem <= qbit ? WIDTH_D'(shifted - {1'b0, dmag})
                       : shifted[WIDTH_D-1:0];
          nq   <= {nq[WIDTH_N-2:0], qbit};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          quotient  <= q_fix;
          remainder <= r_fix;
          ovf       <= ovf_c & ~dzr;
          dz        <= dzr;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_26_12.sv
// Scoreboard bench for divider_26_12: directed vectors,
// expected results and done cycle queued at issue time.
module tb_divider_26_12;

  logic        clock;
  logic        aclr_n;
  logic        clken;
  logic        start;
  logic [25:0] dataa;
  logic [11:0] datab;
  logic        ready;
  logic        done;
  logic [13:0] quotient;
  logic [11:0] remainder;
  logic        ovf;
  logic        dz;

  divider_26_12 dut (
    .clock(clock),
    .aclr_n(aclr_n),
    .clken(clken),
    .start(start),
    .dataa(dataa),
    .datab(datab),
    .ready(ready),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .ovf(ovf),
    .dz(dz)
  );

  typedef struct {
    logic [13:0] q;
    logic [11:0] r;
    logic        ovf;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit last_done = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic chk(input string n, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", n, act, req);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!aclr_n) begin
      last_done = 0;
    end else begin
      if (done && !last_done) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done actual=1 required=0 at cyc=%0d", cyc);
        end else begin
          e = sbq.pop_front();
          chk("quotient", int'($signed(quotient)), int'($signed(e.q)));
          chk("remainder", int'($signed(remainder)), int'($signed(e.r)));
          chk("ovf", int'(ovf), int'(e.ovf));
          chk("dz", int'(dz), int'(e.dz));
          chk("done_cycle", cyc, e.cyc);
        end
      end
      last_done = done;
    end
  end

  task automatic issue(input int a, input int b, input int eq, input int er,
                       input bit eo, input bit ed, input int stall,
                       input bit push);
    int n = 0;
    exp_t e;
    @(negedge clock);
    while (!ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
    dataa = a[25:0];
    datab = b[11:0];
    start = 1'b1;
    if (push) begin
      e.q = eq[13:0];
      e.r = er[11:0];
      e.ovf = eo;
      e.dz = ed;
      e.cyc = cyc + 28 + stall;
      sbq.push_back(e);
    end
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=%0d required=0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    aclr_n = 1'b0;
    clken = 1'b1;
    start = 1'b0;
    dataa = '0;
    datab = '0;
    repeat (3) @(negedge clock);
    chk("rst_ready", int'(ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_dz", int'(dz), 0);
    aclr_n = 1'b1;
    repeat (2) @(negedge clock);

    issue(1000, 7, 142, 6, 0, 0, 0, 1);
    drain();
    issue(-1000, 7, -142, -6, 0, 0, 0, 1);
    drain();
    issue(1000, -7, -142, 6, 0, 0, 0, 1);
    drain();

    issue(-69104, -56, 1234, 0, 0, 0, 0, 1);
    drain();
    issue(-16769024, 2047, -8192, 0, 0, 0, 0, 1);
    drain();
    issue(-16775168, -2048, 8191, 0, 0, 0, 0, 1);
    drain();
    issue(-1001, 13, -77, 0, 0, 0, 0, 1);
    drain();
    issue(16777216, -2048, -8192, 0, 0, 0, 0, 1);
    drain();

    issue(-33554432, -2048, 8191, 0, 1, 0, 0, 1);
    drain();
    issue(33554431, 1, 8191, 0, 1, 0, 0, 1);
    drain();
    issue(-100000, 3, -8192, -1, 1, 0, 0, 1);
    drain();

    // busy-time start with different operands must be dropped
    issue(1000, 7, 142, 6, 0, 0, 0, 1);
    repeat (9) @(negedge clock);
    dataa = 26'h3ff_fffb;
    datab = 12'd3;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    drain();

    issue(-1000, 7, -142, -6, 0, 0, 0, 1);
    issue(1000, -7, -142, 6, 0, 0, 0, 1);
    drain();

    issue(1000, 7, 142, 6, 0, 0, 5, 1);
    repeat (8) @(negedge clock);
    clken = 1'b0;
    repeat (5) @(negedge clock);
    clken = 1'b1;
    drain();

    issue(-1000, -7, 142, -6, 0, 0, 0, 0);
    repeat (10) @(negedge clock);
    aclr_n = 1'b0;
    #1;
    chk("midrst_ready", int'(ready), 1);
    chk("midrst_done", int'(done), 0);
    chk("midrst_quotient", int'(quotient), 0);
    chk("midrst_remainder", int'(remainder), 0);
    chk("midrst_ovf", int'(ovf), 0);
    chk("midrst_dz", int'(dz), 0);
    @(negedge clock);
    aclr_n = 1'b1;
    repeat (40) @(negedge clock);

    issue(5, 0, 8191, 0, 0, 1, 0, 1);
    drain();
    issue(-5, 0, -8192, 0, 0, 1, 0, 1);
    drain();

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/divider_26_12.md
# divider_26_12

Sequential signed divider that undoes `multiplier_14_12`: it takes a 26-bit signed dividend and a 12-bit signed divisor and returns a 14-bit signed quotient and a 12-bit signed remainder. It uses a radix-2 restoring algorithm on magnitudes, one quotient bit per clock, with a start/done handshake. It sits in the DSP path wherever a scaled product must be normalised back, for example gain removal and ratio computation. Latency is fixed so that downstream pipelines can schedule around it.

## Interface
- `WIDTH_N`, 26: dividend width. Also sets the number of iteration cycles.
- `WIDTH_D`, 12: divisor and remainder width.
- `WIDTH_Q`, 14: quotient output width. The quotient saturates to this width.
- `clock` input 1: single clock; all state updates on its rising edge.
- `aclr_n` input 1: reset, asynchronous and active-low.
- `clken` input 1: clock enable. When low, all state, including the FSM and counter, freezes.
- `start` input 1: request. Sampled only when `ready`=1 and `clken`=1.
- `dataa` input `WIDTH_N`: signed dividend, captured on an accepted `start`.
- `datab` input `WIDTH_D`: signed divisor, captured on an accepted `start`.
- `ready` output 1: idle and able to accept `start`.
- `done` output 1: one-cycle pulse; results are valid from this cycle on.
- `quotient` output `WIDTH_Q`: signed, truncated toward zero, saturated.
- `remainder` output `WIDTH_D`: signed, carries the sign of the dividend.
- `ovf` output 1: the quotient did not fit in `WIDTH_Q` and was saturated.
- `dz` output 1: the divisor was zero.

## Operation
- FSM states are `IDLE`, `CALC` and `FIX`.
- **`IDLE`:** `ready`=1. An accepted `start`:
  - latches |`dataa`| and |`datab`|, zero-extended one bit so that -2^25 and -2048 are exact;
  - latches both sign bits;
  - clears the partial remainder;
  - loads the iteration counter with `WIDTH_N`-1;
  - moves to `CALC`.
- **`CALC`:** each enabled cycle performs one step.
  - Shift the next dividend MSB into the partial remainder.
  - Trial-subtract |divisor|. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - When the counter reaches 0, go to `FIX`; otherwise decrement.
- **`FIX`:** a single cycle.
  - Negate the quotient magnitude if the operand signs differ.
  - Negate the remainder if the dividend is negative.
  - Apply the overflow and divide-by-zero rules below.
  - Register the outputs, pulse `done` and return to `IDLE`.
- **Overflow:** the signed quotient lies outside [-8192, 8191].
  - `quotient` = 8191 if positive, -8192 if negative; `ovf`=1.
  - `remainder` = the true remainder, which always fits.
- **Divide by zero:** `datab`=0.
  - The calculation still runs the full latency.
  - `quotient` = 8191 if `dataa`>=0, else -8192; `remainder`=0; `dz`=1; `ovf`=0.
- `ovf` and `dz` update only with `done` and hold alongside the results.
- A `start` while `ready`=0 is ignored; operands are not re-sampled.
- `quotient`, `remainder`, `ovf` and `dz` hold their last values until the next `done`.

## Timing
- **Reset:** on `aclr_n` low, with immediate effect:
  - the FSM goes to `IDLE`;
  - `ready`=1, `done`=0, `quotient`=0, `remainder`=0, `ovf`=0, `dz`=0.
- **Reset mid-operation:** the operation is aborted and no `done` is produced. After reset releases, the next accepted `start` behaves normally.
- **Latency:** with `clken` held high and `start` accepted at rising edge k:
  - `ready`=0 after edge k;
  - `CALC` occupies edges k+1 … k+26;
  - `FIX` is at edge k+27;
  - `done`=1 and `ready`=1 after edge k+27, with the results valid from that point.
  - Total latency is `WIDTH_N`+1 = 27 enabled cycles, independent of operand values.
- **Back-to-back:** `start` asserted in the `done` cycle is accepted at the next edge, giving one result every 28 cycles.
- **Clock enable:** each cycle with `clken`=0 stretches the latency by one cycle. A `done` cycle that coincides with `clken`=0 keeps `done` high until the next enabled edge, so every `done` pulse spans exactly one enabled edge.

## Test plan
- 1000 / 7 → after 27 cycles `quotient`=142, `remainder`=6, `ovf`=0, `dz`=0. Also -1000 / 7 → `quotient`=-142, `remainder`=-6. Also 1000 / -7 → `quotient`=-142, `remainder`=6.
- Round trip with `multiplier_14_12`: for random a∈[-8192, 8191] and b∈[-2048, 2047], b≠0, the input (a·b) / b returns `quotient`=a and `remainder`=0. This must include the corner 16777216 / -2048 → `quotient`=-8192 with `ovf`=0.
- Overflow cases:
  - -33554432 / -2048 → `quotient`=8191, `ovf`=1, `remainder`=0;
  - 33554431 / 1 → `quotient`=8191, `ovf`=1;
  - -100000 / 3 → `quotient`=-8192, `ovf`=1, `remainder`=-1.
- Divide by zero:
  - 5 / 0 → `quotient`=8191, `remainder`=0, `dz`=1, still exactly 27 cycles;
  - -5 / 0 → `quotient`=-8192, `dz`=1.
- Handshake:
  - a `start` pulsed with new operands at cycle 10 of a busy operation is ignored, and the first result is unchanged;
  - `start` in the `done` cycle gives the second `done` 28 cycles after the first.
- Control:
  - 5 cycles of `clken`=0 during `CALC` delay `done` by exactly 5 cycles with the same result;
  - `aclr_n` pulsed low at cycle 12 returns all outputs to 0 and `ready`=1, with no `done` pulse.
